// File: rtl/mfp_uart_tx_pkg.sv
// Shared definitions for the AHB UART transmitter: register word indices, STATUS bit
// positions, serializer state encoding and small helpers.
package mfp_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_IRQ_EN  = 2'd3;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_OVF       = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } ser_state_e;

    // A programmed divisor of zero behaves as one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    function automatic logic [7:0] sat_count(input int unsigned c);
        return (c > 255) ? 8'hFF : 8'(c);
    endfunction

endpackage

// File: rtl/mfp_uart_tx_serializer.sv
// 8N1 serializer: takes a byte on valid & ready, latches the divisor, and shifts the
// frame out LSB first with a registered, glitch-free line output.
module mfp_uart_tx_serializer
    import mfp_uart_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  data,
    input  logic [15:0] divisor,
    output logic        ready,
    output logic        busy,
    output logic        tx
);

    ser_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        tx_q, tx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            div_q   <= 16'd1;
            bit_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        ready   = (state_q == StIdle);
        busy    = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    div_d   = eff_div(divisor);
                    cnt_d   = eff_div(divisor) - 16'd1;
                    data_d  = data;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase

        // Line level follows the state being entered so it changes on the same edge.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = data_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: rtl/mfp_ahb_uart_tx_slave.sv
// AHB-Lite responder for UART transmit: register front end, byte FIFO, level interrupt,
// and an instance of the 8N1 serializer.
module mfp_ahb_uart_tx_slave
    import mfp_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX,
    output logic        UART_INT
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Bus data-phase tracking
    logic       dp_valid_q;
    logic       dp_write_q;
    logic [1:0] dp_addr_q;
    logic       wr_commit, wr_txdata, wr_status, wr_divisor, wr_irq_en;

    // FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;

    // Registers
    logic        ovf_q, ovf_d;
    logic [15:0] divisor_q, divisor_d;
    logic        irq_en_q, irq_en_d;

    logic        ser_ready, ser_busy;
    logic [31:0] status_word;
    logic        unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
        end else if (HREADY) begin
            dp_valid_q <= HSEL & HTRANS[1];
            dp_write_q <= HWRITE;
            dp_addr_q  <= HADDR[3:2];
        end
    end

    assign wr_commit  = dp_valid_q & dp_write_q & HREADY;
    assign wr_txdata  = wr_commit & (dp_addr_q == REG_TXDATA);
    assign wr_status  = wr_commit & (dp_addr_q == REG_STATUS);
    assign wr_divisor = wr_commit & (dp_addr_q == REG_DIVISOR);
    assign wr_irq_en  = wr_commit & (dp_addr_q == REG_IRQ_EN);

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = ser_ready & ~empty;
    // A pop on the same edge frees the slot, so a write to a full FIFO still lands.
    assign push  = wr_txdata & (~full | pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        divisor_d = divisor_q;
        irq_en_d  = irq_en_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (wr_txdata && !push) begin
            ovf_d = 1'b1;
        end else if (wr_status && HWDATA[STAT_OVF]) begin
            ovf_d = 1'b0;
        end

        if (wr_divisor) begin
            divisor_d = HWDATA[15:0];
        end
        if (wr_irq_en) begin
            irq_en_d = HWDATA[0];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            divisor_q <= DEFAULT_DIV;
            irq_en_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            divisor_q <= divisor_d;
            irq_en_q  <= irq_en_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr_q] <= HWDATA[7:0];
        end
    end

    mfp_uart_tx_serializer u_serializer (
        .clk     (HCLK),
        .rst     (HRESET),
        .valid   (~empty),
        .data    (mem[rd_ptr_q]),
        .divisor (divisor_q),
        .ready   (ser_ready),
        .busy    (ser_busy),
        .tx      (UART_TX)
    );

    always_comb begin
        status_word                           = 32'd0;
        status_word[STAT_BUSY]                = ser_busy;
        status_word[STAT_FULL]                = full;
        status_word[STAT_EMPTY]               = empty;
        status_word[STAT_OVF]                 = ovf_q;
        status_word[STAT_COUNT_LSB +: 8]      = sat_count(32'(count_q));
    end

    always_comb begin
        HRDATA = 32'd0;
        if (dp_valid_q && !dp_write_q) begin
            unique case (dp_addr_q)
                REG_TXDATA:  HRDATA = 32'd0;
                REG_STATUS:  HRDATA = status_word;
                REG_DIVISOR: HRDATA = {16'd0, divisor_q};
                REG_IRQ_EN:  HRDATA = {31'd0, irq_en_q};
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign UART_INT  = irq_en_q & empty & ~ser_busy;

endmodule

// File: tb/tb_mfp_ahb_uart_tx_slave.sv
// Directed bench for the AHB UART transmitter: register vector table plus timed
// sequences for framing, overflow, full push/pop, interrupt and reset.
module tb_mfp_ahb_uart_tx_slave;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL   = 1'b0;
    logic [3:0]  HADDR  = 4'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE  = 3'b010;
    logic [31:0] HWDATA = 32'h0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        UART_TX;
    logic        UART_INT;

    assign HREADY = HREADYOUT;

    mfp_ahb_uart_tx_slave #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .UART_TX   (UART_TX),
        .UART_INT  (UART_INT)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // All bus tasks are entered 1 ns after a rising edge and return 1 ns after one.
    task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    // Pipelined TXDATA writes; the first commits two edges after entry.
    task automatic burst(input logic [7:0] b [16], input int n);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'h0;
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #1;
            HWDATA = {24'h0, b[i]};
            if (i == n - 1) begin
                HSEL = 1'b0; HTRANS = 2'b00;
            end
        end
        @(posedge HCLK); #1;
    endtask

    // Line receiver, samples mid-bit using the divisor the bench says is in use.
    logic       rx_en   = 1'b0;
    int         rx_div  = 100;
    int         rx_ferr = 0;
    logic [7:0] rx_q [$];

    initial begin
        forever begin
            @(posedge HCLK); #1;
            if (rx_en && UART_TX === 1'b0) begin
                int         d;
                logic [7:0] b;
                d = rx_div;
                repeat (d + d / 2) @(posedge HCLK);
                #1 b[0] = UART_TX;
                for (int i = 1; i < 8; i++) begin
                    repeat (d) @(posedge HCLK);
                    #1 b[i] = UART_TX;
                end
                repeat (d) @(posedge HCLK);
                #1 if (UART_TX !== 1'b1) rx_ferr++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic wait_rx(input string name, input int n, input int limit);
        int t = 0;
        while (rx_q.size() < n && t < limit) begin
            @(posedge HCLK); #1;
            t++;
        end
        chk({name, "_count"}, rx_q.size(), n);
        chk({name, "_framing"}, rx_ferr, 0);
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_int;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] rd;
    logic [31:0] rd2;
    logic [7:0]  bb [16];
    int          s;
    int          target;

    initial begin
        vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b0, 4'h8, 32'h0,        32'h0000_01B2, 1'b0};
        vecs[2]  = '{1'b0, 4'hC, 32'h0,        32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 4'h6, 32'h0,        32'h0000_0004, 1'b0};
        vecs[5]  = '{1'b1, 4'h8, 32'hFFFF_0004, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 4'h8, 32'h0,        32'h0000_0004, 1'b0};
        vecs[7]  = '{1'b1, 4'hC, 32'hFFFF_FFFE, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 4'hC, 32'h0,        32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b1, 4'hC, 32'h0000_0001, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 4'hC, 32'h0,        32'h0000_0001, 1'b1};
        vecs[11] = '{1'b1, 4'hC, 32'h0000_0000, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 4'h4, 32'h0,        32'h0000_0004, 1'b0};
        vecs[13] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 4'h4, 32'h0,        32'h0000_0004, 1'b0};

        // Reset
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_tx", UART_TX, 1);
        chk("rst_int", UART_INT, 0);
        chk("rst_hrdata", HRDATA, 0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        chk("hreadyout", HREADYOUT, 1);
        chk("hresp", HRESP, 0);
        chk("idle_tx", UART_TX, 1);

        // Register table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                ahb_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                ahb_read(vecs[i].addr, rd);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d_int", i), UART_INT, vecs[i].exp_int);
        end
        chk("hrdata_no_read", HRDATA, 0);

        // Single byte 0xA5 at DIVISOR=4 (set by the table)
        ahb_write(4'h0, 32'hA5);
        chk("sb_pre_start", UART_TX, 1);
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge HCLK); #1;
                    chk($sformatf("sb_clk%0d", k), UART_TX, frame_bit(8'hA5, k / 4));
                end
            end
            begin
                repeat (38) @(posedge HCLK);
                #1 ahb_read(4'h4, rd2);
                chk("sb_busy", rd2, 32'h0000_0005);
            end
        join
        ahb_read(4'h4, rd);
        chk("sb_done", rd, 32'h0000_0004);

        // Overflow: 10 back-to-back bytes at DIVISOR=100
        ahb_write(4'h8, 32'd100);
        rx_div = 100;
        rx_q.delete();
        rx_en = 1'b1;
        for (int i = 0; i < 10; i++) bb[i] = 8'h10 + 8'(i);
        burst(bb, 10);
        ahb_read(4'h4, rd);
        chk("ovf_status", rd, 32'h0000_080B);
        ahb_write(4'h4, 32'h8);
        ahb_read(4'h4, rd);
        chk("ovf_cleared", rd, 32'h0000_0803);
        wait_rx("ovf_rx", 9, 12000);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) chk($sformatf("ovf_byte%0d", i), rx_q[i], 8'h10 + 8'(i));
        end
        repeat (60) @(posedge HCLK);
        #1;

        // Write lands on the very edge the serializer pops from a full FIFO
        rx_q.delete();
        for (int i = 0; i < 9; i++) bb[i] = 8'h30 + 8'(i);
        s = cyc;
        burst(bb, 9);
        target = s + 1002;
        while (cyc < target) begin
            @(posedge HCLK); #1;
        end
        ahb_write(4'h0, 32'h3A);
        ahb_read(4'h4, rd);
        chk("pp_status", rd, 32'h0000_0803);
        wait_rx("pp_rx", 10, 12000);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size())
                chk($sformatf("pp_byte%0d", i), rx_q[i], (i < 9) ? 8'h30 + 8'(i) : 8'h3A);
        end
        repeat (60) @(posedge HCLK);
        #1;
        rx_en = 1'b0;

        // Interrupt plus divisor change between frames
        ahb_write(4'h8, 32'd4);
        ahb_write(4'hC, 32'd1);
        chk("irq_idle", UART_INT, 1);
        bb[0] = 8'h5A;
        bb[1] = 8'hC3;
        s = cyc;
        fork
            begin
                burst(bb, 2);
                ahb_write(4'h8, 32'd8);
            end
            begin
                while (cyc < s + 3) begin
                    @(posedge HCLK); #1;
                end
                for (int j = 0; j < 122; j++) begin
                    logic e;
                    if (j > 0) begin
                        @(posedge HCLK); #1;
                    end
                    if (j < 40)       e = frame_bit(8'h5A, j / 4);
                    else if (j == 40) e = 1'b1;
                    else if (j < 121) e = frame_bit(8'hC3, (j - 41) / 8);
                    else              e = 1'b1;
                    chk($sformatf("irq_tx%0d", j), UART_TX, e);
                    chk($sformatf("irq_int%0d", j), UART_INT, (j == 121) ? 1 : 0);
                end
            end
        join

        // Reset in the middle of a data bit
        ahb_write(4'h0, 32'h00);
        ahb_write(4'h0, 32'h00);
        repeat (20) @(posedge HCLK);
        #1 chk("rm_data_low", UART_TX, 0);
        #2 HRESET = 1'b1;
        #1 chk("rm_tx_async", UART_TX, 1);
        chk("rm_int", UART_INT, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        ahb_read(4'h4, rd);
        chk("rm_status", rd, 32'h0000_0004);
        ahb_read(4'h8, rd);
        chk("rm_divisor", rd, 32'h0000_01B2);
        repeat (30) @(posedge HCLK);
        #1 chk("rm_tx_quiet", UART_TX, 1);
        ahb_read(4'h4, rd);
        chk("rm_status_later", rd, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_uart_tx_slave.md
Name: mfp_ahb_uart_tx_slave

Overview:
- AHB-Lite responder that lets the MIPSfpga core transmit bytes on a UART line.
- It is the output-direction counterpart of the UART boot loader, which receives bytes and acts as an AHB initiator.
- Sits on one matrix slave port and decodes HSEL from the matrix.
- Contains a byte FIFO, an 8N1 serializer with a programmable divisor, and a level interrupt.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..256.
- DEFAULT_DIV, 16'd434, reset value of DIVISOR (clocks per bit; 50 MHz / 115200).

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from matrix decoder.
- HADDR  in  4  byte address [3:0]; only [3:2] decoded.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; all accesses treated as word.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-wide ready.
- HRDATA  out  32  read data (data phase).
- HREADYOUT  out  1  constant 1 (zero wait state).
- HRESP  out  1  constant 0 (OKAY).
- UART_TX  out  1  serial line, idle high.
- UART_INT  out  1  level interrupt.

Behaviour:
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. HADDR[3:2] and HWRITE are registered, along with a valid flag that lasts for the following data phase.
- Writes commit at the edge that ends the data phase, using HWDATA. Reads drive HRDATA combinationally from the registered address during the data phase; HRDATA is 0 when no read is valid.
- Register map:
  - 0x0 TXDATA. Write pushes HWDATA[7:0]. If the FIFO is full, the byte is dropped and OVF is set. Reads return 0.
  - 0x4 STATUS (read): [0] BUSY, [1] FULL, [2] EMPTY, [3] OVF (sticky), [15:8] FIFO count. Writing 1 to bit 3 clears OVF.
  - 0x8 DIVISOR: [15:0] read/write. A value of 0 is treated as 1. The new value takes effect at the next start bit; a frame in progress keeps its latched divisor.
  - 0xC IRQ_EN: bit [0] read/write.
- Reset values: UART_TX=1, HRDATA=0, UART_INT=0, FIFO empty, OVF=0, DIVISOR=DEFAULT_DIV, IRQ_EN=0, serializer IDLE.
- Serializer FSM (states IDLE, START, DATA, STOP):
  - IDLE: if FIFO not empty, pop the byte, latch the divisor, go to START. UART_TX goes low at the pop edge.
  - START: one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each; the bit index counts 0..7, then STOP.
  - STOP: UART_TX=1 for one bit period, then IDLE.
  - The FIFO is checked again in IDLE on the next cycle, so back-to-back frames have one extra idle clock.
  - The bit-period counter counts from latched DIVISOR-1 down to 0.
- Latency: a TXDATA write committing at edge E into an empty FIFO with the serializer idle gives the pop at E+1, with UART_TX low from E+1. One frame lasts 10×DIV clocks.
- BUSY = (state != IDLE).
- UART_INT = IRQ_EN & EMPTY & ~BUSY (level, no latch).
- FIFO uses wrap-around pointers with a separate count of width log2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle while full: both happen, count is unchanged, no overflow.
  - Push and pop in the same cycle while empty: impossible, since a pop requires not-empty.
  - The count is reported saturated into 8 bits (FIFO_DEPTH=256 reads as 0xFF).
- Reset mid-frame: UART_TX returns high asynchronously and the FIFO contents are discarded.
- Writes to unmapped bits are ignored.

Decomposition:
- Shared package/header mfp_uart_tx.vh holds:
  - register offsets (TXDATA=0, STATUS=1, DIVISOR=2, IRQ_EN=3 as word indices);
  - STATUS bit indices;
  - FSM state encodings.
- One natural sub-module: mfp_uart_tx_serializer, containing the FSM, the bit counter and the divisor latch. Handshake: valid / ready / byte in, with busy out.
- The FIFO and the AHB register front end stay in the top module.

Test Plan:
- Reset: after release, UART_TX=1, STATUS reads 0x00000004 (EMPTY), DIVISOR reads 434, UART_INT=0.
- Single byte: with DIVISOR=4, write 0xA5 to TXDATA. UART_TX shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit exactly 4 clocks; start falls 1 clock after the write data phase. BUSY=1 throughout, and BUSY=0 after 40 clocks.
- FIFO overflow: FIFO_DEPTH=8, DIVISOR=100, write 10 bytes back to back. The first byte is popped immediately, so 9 are accepted (1 in flight plus 8 queued) and the 10th sets OVF. STATUS shows FULL=1 and count=8. Writing 0x8 to STATUS clears OVF. All 9 bytes are later emitted in order.
- Push and pop in the same cycle while full: time a TXDATA write to the cycle of the serializer pop. The count stays 8, OVF stays 0, and the byte appears last.
- Interrupt and divisor change: set IRQ_EN=1 and send 2 bytes. UART_INT=0 during transmission and rises the cycle after the final stop bit ends. Writing DIVISOR=8 mid-frame leaves the current frame at 4 clocks per bit; the next frame uses 8.
- Reset mid-frame: assert HRESET during DATA. UART_TX=1 immediately, and STATUS reads EMPTY with count 0 afterwards.
